icache_assoc: RTL

//  Parametrised set-associative instruction cache with built-in miss refill and flush.

---
 rtl/icache_assoc.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
// Set-associative instruction cache (1 or 2 ways) with combinational hit path,
// byte-serial miss refill, LRU replacement and a one-set-per-cycle flush sweep.
module icache_assoc #(
   parameter int ADDR_W  = 32,
   parameter int INDEX_W = 8,
   parameter int TAG_W   = 7,
   parameter int WAYS    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ready,
   input  logic              req_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   output logic              hit_o,
   output logic [31:0]       inst_o,
   output logic              busy_o,
   input  logic              flush_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_valid_i,
   input  logic [7:0]        mem_rdata_i
);
   localparam int SETS = 1 << INDEX_W;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE, FLUSH} state_t;

   state_t              state_r, state_s;
   logic [WAYS-1:0]     valid_r [SETS];
   logic [TAG_W-1:0]    tag_r   [WAYS][SETS];
   logic [31:0]         data_r  [WAYS][SETS];
   logic [SETS-1:0]     lru_r;
   logic [ADDR_W-1:0]   refill_addr_r;
   logic [1:0]          cnt_r;
   logic [31:0]         line_buf_r;
   logic                flush_pend_r;
   logic [INDEX_W-1:0]  flush_idx_r;

   logic [INDEX_W-1:0]  req_idx_s, ref_idx_s;
   logic [TAG_W-1:0]    req_tag_s, ref_tag_s;
   logic                lookup_s, match_s, miss_s, hit_way_s, victim_s;
   logic [31:0]         hit_data_s;

   assign req_idx_s = req_addr_i[2 +: INDEX_W];
   assign req_tag_s = req_addr_i[2+INDEX_W +: TAG_W];
   assign ref_idx_s = refill_addr_r[2 +: INDEX_W];
   assign ref_tag_s = refill_addr_r[2+INDEX_W +: TAG_W];

   assign lookup_s = ready & req_i & (state_r == IDLE);
   assign hit_o    = lookup_s & match_s;
   assign miss_s   = lookup_s & ~match_s;
   assign inst_o   = hit_o ? hit_data_s : 32'd0;
   assign busy_o   = (state_r != IDLE);
   assign mem_req_o  = (state_r == REFILL);
   assign mem_addr_o = (state_r == REFILL) ? {refill_addr_r[ADDR_W-1:2], cnt_r} : '0;

   // Tag compare across ways; the descending loop gives way0 priority
   always_comb begin
      match_s    = 1'b0;
      hit_way_s  = 1'b0;
      hit_data_s = 32'd0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_r[req_idx_s][w] && (tag_r[w][req_idx_s] == req_tag_s)) begin
            match_s    = 1'b1;
            hit_way_s  = w[0];
            hit_data_s = data_r[w][req_idx_s];
         end else begin
            match_s    = match_s;
         end
      end
   end

   // Victim selection: lowest invalid way, else the LRU way
   always_comb begin
      victim_s = lru_r[ref_idx_s];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_r[ref_idx_s][w]) begin
            victim_s = w[0];
         end else begin
            victim_s = victim_s;
         end
      end
      if (WAYS == 1) begin
         victim_s = 1'b0;
      end else begin
         victim_s = victim_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (flush_i)     state_s = FLUSH;
            else if (miss_s) state_s = REFILL;
            else             state_s = IDLE;
         end
         REFILL: begin
            if (mem_valid_i && (cnt_r == 2'd3)) state_s = WRITE;
            else                                state_s = REFILL;
         end
         WRITE: begin
            if (flush_pend_r || flush_i) state_s = FLUSH;
            else                         state_s = IDLE;
         end
         FLUSH: begin
            if (flush_idx_r == {INDEX_W{1'b1}}) state_s = IDLE;
            else                                state_s = FLUSH;
         end
         default: state_s = IDLE;
      endcase
   end

   // Control state, valid/LRU bits and refill datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= IDLE;
         cnt_r         <= 2'd0;
         refill_addr_r <= '0;
         line_buf_r    <= 32'd0;
         flush_pend_r  <= 1'b0;
         flush_idx_r   <= '0;
         lru_r         <= '0;
         for (int s = 0; s < SETS; s++) valid_r[s] <= '0;
      end else begin
         state_r <= state_s;
         case (state_r)
            IDLE: begin
               flush_idx_r <= '0;
               if (!flush_i && miss_s) begin
                  refill_addr_r <= {req_addr_i[ADDR_W-1:2], 2'b00};
                  cnt_r         <= 2'd0;
               end
               if (hit_o) lru_r[req_idx_s] <= ~hit_way_s;
            end
            REFILL: begin
               if (flush_i) flush_pend_r <= 1'b1;
               if (mem_valid_i) begin
                  line_buf_r[{cnt_r, 3'b000} +: 8] <= mem_rdata_i;
                  cnt_r <= cnt_r + 2'd1;
               end
            end
            WRITE: begin
               valid_r[ref_idx_s][victim_s] <= 1'b1;
               lru_r[ref_idx_s]             <= ~victim_s;
               flush_pend_r                 <= 1'b0;
               flush_idx_r                  <= '0;
            end
            FLUSH: begin
               valid_r[flush_idx_r] <= '0;
               lru_r[flush_idx_r]   <= 1'b0;
               flush_idx_r          <= flush_idx_r + 1'b1;
            end
            default: flush_pend_r <= 1'b0;
         endcase
      end
   end

   // Tag and data arrays hold no reset; validity is tracked separately
   always_ff @(posedge clk) begin
      if (state_r == WRITE) begin
         tag_r[victim_s][ref_idx_s]  <= ref_tag_s;
         data_r[victim_s][ref_idx_s] <= line_buf_r;
      end
   end
endmodule
